// File: rtl/msrv32_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : msrv32_fetch_queue
// Purpose  : Instruction fetch and buffering stage. Issues sequential fetch
//            requests to instruction memory, collects the in-order responses
//            into a DEPTH-entry FIFO and presents {pc, instr} to decode
//            through a valid/ready handshake. A redirect (flush_in) discards
//            every buffered entry and silently drops responses still in
//            flight for the old stream.
// Ports    : clk_in, rst_in           - clock, synchronous active-high reset
//            flush_in, redirect_pc_in - redirect request and new fetch target
//            imaddr_out, imreq_out,
//            imreq_ack_in             - instruction memory request channel
//            instr_rdata_in,
//            instr_rvalid_in          - in-order memory response channel
//            instr_valid_out, instr_out,
//            pc_out, instr_ready_in   - decode handshake (FIFO head)
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] imaddr_out,
    output logic        imreq_out,
    input  logic        imreq_ack_in,
    input  logic [31:0] instr_rdata_in,
    input  logic        instr_rvalid_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic        instr_ready_in
);

    localparam int unsigned   c_PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   c_CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0]   c_NOP     = 32'h0000_0013;
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW+1:0] c_DEPTH_W = (c_CW + 2)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_outstanding;   // live requests awaiting a response
    logic [c_CW-1:0] r_drop;          // stale responses still to be discarded
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [31:0]     r_pc_hold;       // last pc shown, displayed while empty
    logic            r_init_done;     // low for the first cycle after reset
    logic [31:0]     r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            w_empty;
    logic            w_valid;
    logic            w_pop;
    logic [c_CW+1:0] w_in_use;
    logic [c_CW+1:0] w_limit;
    logic            w_credit;
    logic            w_req;
    logic            w_accept;
    logic            w_drop_nz;
    logic            w_rsp_live;
    logic            w_rsp_dead;
    logic            w_push;
    logic [c_CW-1:0] w_accept_ext;
    logic [c_CW-1:0] w_live_ext;
    logic [c_CW-1:0] w_push_ext;
    logic [c_CW-1:0] w_pop_ext;
    logic [c_CW-1:0] w_rvalid_ext;
    logic [31:0]     w_redirect_pc;
    logic            w_unused_redirect_lsb;

    assign w_empty   = (r_count == '0);
    assign w_valid   = ~w_empty & ~rst_in;
    assign w_pop     = w_valid & instr_ready_in;

    // Every slot is reserved either by a buffered entry, a live request or a
    // stale request whose response must still arrive. A pop in this cycle
    // frees a slot early enough for a new request, because that request's
    // response cannot land before the next cycle. This keeps a 1-cycle
    // memory streaming one instruction per cycle with only two entries.
    assign w_in_use  = {2'b00, r_outstanding} + {2'b00, r_count} + {2'b00, r_drop};
    assign w_limit   = c_DEPTH_W + {{(c_CW + 1){1'b0}}, w_pop};
    assign w_credit  = (w_in_use < w_limit);

    assign w_req     = w_credit & ~flush_in & ~rst_in & r_init_done;
    assign w_accept  = w_req & imreq_ack_in;

    assign w_drop_nz  = (r_drop != '0);
    assign w_rsp_live = instr_rvalid_in & ~w_drop_nz;
    assign w_rsp_dead = instr_rvalid_in &  w_drop_nz;
    assign w_push     = w_rsp_live & ~flush_in;

    assign w_accept_ext = {{(c_CW - 1){1'b0}}, w_accept};
    assign w_live_ext   = {{(c_CW - 1){1'b0}}, w_rsp_live};
    assign w_push_ext   = {{(c_CW - 1){1'b0}}, w_push};
    assign w_pop_ext    = {{(c_CW - 1){1'b0}}, w_pop};
    assign w_rvalid_ext = {{(c_CW - 1){1'b0}}, instr_rvalid_in};

    // Redirect targets are word aligned; the two low bits carry no meaning.
    assign w_redirect_pc         = {redirect_pc_in[31:2], 2'b00};
    assign w_unused_redirect_lsb = ^redirect_pc_in[1:0];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imreq_out       = w_req;
    assign imaddr_out      = rst_in ? RESET_PC : r_fetch_pc;
    assign instr_valid_out = w_valid;
    assign instr_out       = w_valid ? r_mem_instr[r_rd_ptr] : c_NOP;
    assign pc_out          = rst_in  ? RESET_PC :
                             w_empty ? r_pc_hold : r_mem_pc[r_rd_ptr];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pc_hold     <= RESET_PC;
            r_init_done   <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
            r_pc_hold   <= pc_out;
            if (flush_in) begin
                r_fetch_pc    <= w_redirect_pc;
                r_rsp_pc      <= w_redirect_pc;
                r_count       <= '0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_outstanding <= '0;
                // Every request still in flight, live or already stale, now
                // owes one response that must be thrown away. A response
                // arriving in this very cycle settles one of them.
                r_drop        <= r_outstanding + r_drop - w_rvalid_ext;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                r_outstanding <= r_outstanding + w_accept_ext - w_live_ext;
                if (w_rsp_dead) begin
                    r_drop <= r_drop - c_CNT_ONE;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                r_count <= r_count + w_push_ext - w_pop_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents are qualified by r_count, so no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_push && !rst_in) begin
            r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
            r_mem_instr[r_wr_ptr] <= instr_rdata_in;
        end
    end

endmodule
`default_nettype wire
